// File: rtl/cache_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cache_mem_responder                                            |
// | Purpose : Memory-side responder for a direct-mapped write-through cache. |
// |           Serves 32-bit block refills after a fixed latency and commits  |
// |           byte write-throughs from a posted-write buffer into an 8 KB    |
// |           byte-addressed backing store (2048 x 32-bit words).            |
// | Ports   : clk, resetn (async, active-low)                                |
// |           rreq_to_mem / raddr_to_mem          : level refill request     |
// |           wreq_to_mem / waddr_to_mem / wdata  : byte write request       |
// |           rdata_from_mem / rvalid_from_mem    : refill block + pulse     |
// |           wr_overflow                         : sticky dropped-write     |
// |           busy                                : FSM active or buffer used|
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cache_mem_responder #(
    parameter int READ_LATENCY = 4,
    parameter int WBUF_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rreq_to_mem,
    input  logic [12:0] raddr_to_mem,
    input  logic        wreq_to_mem,
    input  logic [12:0] waddr_to_mem,
    input  logic [7:0]  wdata_to_mem,
    output logic [31:0] rdata_from_mem,
    output logic        rvalid_from_mem,
    output logic        wr_overflow,
    output logic        busy
);

    localparam int         c_PTR_W = $clog2(WBUF_DEPTH);
    localparam logic [3:0] c_LAT   = 4'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_count;
    logic [10:0]        r_idx;
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic [12:0]        r_buf_addr [WBUF_DEPTH];
    logic [7:0]         r_buf_data [WBUF_DEPTH];
    logic               r_prev_wreq;
    logic               r_last_valid;
    logic [12:0]        r_last_addr;
    logic [7:0]         r_last_data;
    logic [31:0]        r_mem [2048];

    logic [c_PTR_W:0]   w_level;
    logic               w_empty;
    logic               w_full;
    logic               w_deq;
    logic               w_dup;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;
    logic               w_empty_next;
    logic [12:0]        w_head_addr;
    logic [7:0]         w_head_data;
    logic               w_unused;

    // Block refills are word aligned; the byte offset is deliberately ignored.
    assign w_unused = ^raddr_to_mem[1:0];

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Extra pointer MSB differs only when the write pointer has lapped the read pointer.
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    // Draining is frozen in RD_WAIT so a pending refill sees a stable snapshot.
    assign w_deq = !w_empty && ((r_state == S_IDLE) || (r_state == S_RELEASE));

    // A held request repeating the last enqueued address/data is one write, not many.
    assign w_dup = wreq_to_mem && r_prev_wreq && r_last_valid &&
                   (waddr_to_mem == r_last_addr) && (wdata_to_mem == r_last_data);

    assign w_push_req = wreq_to_mem && !w_dup;
    assign w_push     = w_push_req && (!w_full || w_deq);
    assign w_drop     = w_push_req && w_full && !w_deq;

    // Capture only when nothing will remain buffered after this edge, including a
    // write that enqueues on the same edge; this gives read-after-write ordering.
    assign w_empty_next = !w_push &&
                          (w_empty || (w_deq && (w_level == (c_PTR_W+1)'(1))));

    assign w_head_addr = r_buf_addr[r_rd_ptr[c_PTR_W-1:0]];
    assign w_head_data = r_buf_data[r_rd_ptr[c_PTR_W-1:0]];

    assign busy = (r_state != S_IDLE) || !w_empty;

    // Buffer payload and backing store carry no reset: storage survives reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_addr[r_wr_ptr[c_PTR_W-1:0]] <= waddr_to_mem;
            r_buf_data[r_wr_ptr[c_PTR_W-1:0]] <= wdata_to_mem;
        end
        if (w_deq) begin
            r_mem[w_head_addr[12:2]][{w_head_addr[1:0], 3'b000} +: 8] <= w_head_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_count         <= 4'd0;
            r_idx           <= 11'd0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_prev_wreq     <= 1'b0;
            r_last_valid    <= 1'b0;
            r_last_addr     <= 13'd0;
            r_last_data     <= 8'd0;
            wr_overflow     <= 1'b0;
            rdata_from_mem  <= 32'd0;
            rvalid_from_mem <= 1'b0;
        end else begin
            rvalid_from_mem <= 1'b0;
            r_prev_wreq     <= wreq_to_mem;

            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_last_valid <= 1'b1;
                r_last_addr  <= waddr_to_mem;
                r_last_data  <= wdata_to_mem;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                wr_overflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (rreq_to_mem && w_empty_next) begin
                        r_idx   <= raddr_to_mem[12:2];
                        r_count <= c_LAT;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (!rreq_to_mem) begin
                        r_count <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (r_count == 4'd1) begin
                        rdata_from_mem  <= r_mem[r_idx];
                        rvalid_from_mem <= 1'b1;
                        r_count         <= 4'd0;
                        r_state         <= S_RELEASE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                S_RELEASE: begin
                    // Request is still held just after the pulse; wait for it to drop.
                    if (!rreq_to_mem) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_cache_mem_responder                                         |
// | Purpose : Scoreboard bench for cache_mem_responder. Directed refills and |
// |           write-throughs push expected {data, edge} entries; a negedge   |
// |           monitor pops and compares on every rvalid pulse. A second      |
// |           instance with a longer latency exercises buffer overflow.      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_cache_mem_responder;

    localparam int L  = 4;
    localparam int L2 = 8;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        rreq, wreq;
    logic [12:0] raddr, waddr;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic        rvalid, ovf, busy;

    logic        rreq2, wreq2;
    logic [12:0] raddr2, waddr2;
    logic [7:0]  wdata2;
    logic [31:0] rdata2;
    logic        rvalid2, ovf2, busy2;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    cache_mem_responder #(.READ_LATENCY(L), .WBUF_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .rreq_to_mem(rreq), .raddr_to_mem(raddr),
        .wreq_to_mem(wreq), .waddr_to_mem(waddr), .wdata_to_mem(wdata),
        .rdata_from_mem(rdata), .rvalid_from_mem(rvalid),
        .wr_overflow(ovf), .busy(busy)
    );

    cache_mem_responder #(.READ_LATENCY(L2), .WBUF_DEPTH(4)) u_ovf (
        .clk(clk), .resetn(resetn),
        .rreq_to_mem(rreq2), .raddr_to_mem(raddr2),
        .wreq_to_mem(wreq2), .waddr_to_mem(waddr2), .wdata_to_mem(wdata2),
        .rdata_from_mem(rdata2), .rvalid_from_mem(rvalid2),
        .wr_overflow(ovf2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Refill on an idle, drained instance: capture at the next edge, pulse
    // lat edges later, request held one extra edge to probe double service.
    task automatic refill(input bit sel, input logic [12:0] a, input logic [31:0] exp_d);
        int lat = sel ? L2 : L;
        if (sel) begin
            rreq2 = 1'b1; raddr2 = a;
            q1.push_back('{data: exp_d, cyc: cyc + 1 + lat});
        end else begin
            rreq = 1'b1; raddr = a;
            q0.push_back('{data: exp_d, cyc: cyc + 1 + lat});
        end
        repeat (lat + 2) tick();
        rreq  = 1'b0;
        rreq2 = 1'b0;
        repeat (3) tick();
    endtask

    // Monitor: every pulse must match the oldest expectation, in value and edge.
    always @(negedge clk) begin
        if (rvalid) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid actual=1 required=0 rdata=%h (edge %0d)", rdata, cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("rdata", rdata, e.data);
                check("rvalid_edge", 32'(cyc), 32'(e.cyc));
            end
        end
        if (rvalid2) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid2 actual=1 required=0 rdata=%h (edge %0d)", rdata2, cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("rdata2", rdata2, e.data);
                check("rvalid2_edge", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rreq = 0; wreq = 0; raddr = 0; waddr = 0; wdata = 0;
        rreq2 = 0; wreq2 = 0; raddr2 = 0; waddr2 = 0; wdata2 = 0;
        for (int i = 0; i < 2048; i++) begin
            dut.r_mem[i]   = 32'd0;
            u_ovf.r_mem[i] = 32'd0;
        end
        dut.r_mem[11'h000]   = 32'hDDCCBBAA;
        dut.r_mem[11'h041]   = 32'h87654321;
        dut.r_mem[11'h050]   = 32'h11223344;
        dut.r_mem[11'h080]   = 32'hA5A5A5A5;
        u_ovf.r_mem[11'h0C0] = 32'hCAFEF00D;

        #1;
        check("reset_rdata",  rdata,  32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_ovf",    32'(ovf),    32'd0);
        check("reset_busy",   32'(busy),   32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        tick();

        // Basic refill; byte offset ignored; no second pulse while held.
        refill(0, 13'h003, 32'hDDCCBBAA);

        // Write then read next cycle: byte lane 2 of word 0x41.
        wreq = 1; waddr = 13'h106; wdata = 8'h5A;
        tick();
        wreq = 0;
        refill(0, 13'h104, 32'h875A4321);

        // Same-edge write and read: read waits one edge behind the write.
        wreq = 1; waddr = 13'h141; wdata = 8'hC3;
        rreq = 1; raddr = 13'h140;
        q0.push_back('{data: 32'h1122C344, cyc: cyc + 2 + L});
        tick();
        wreq = 0;
        repeat (L + 2) tick();
        rreq = 0;
        repeat (3) tick();

        // Writes during RD_WAIT are invisible to that read, visible to the next.
        rreq = 1; raddr = 13'h200;
        q0.push_back('{data: 32'hA5A5A5A5, cyc: cyc + 1 + L});
        tick();
        for (int i = 0; i < 4; i++) begin
            wreq = 1; waddr = 13'h200 + 13'(i); wdata = 8'((i + 1) * 17);
            tick();
        end
        wreq = 0;
        tick();
        rreq = 0;
        repeat (6) tick();
        check("drain_busy", 32'(busy), 32'd0);
        refill(0, 13'h200, 32'h44332211);

        // Overflow on the long-latency instance: 5 writes while draining is frozen.
        rreq2 = 1; raddr2 = 13'h300;
        q1.push_back('{data: 32'hCAFEF00D, cyc: cyc + 1 + L2});
        tick();
        for (int i = 0; i < 5; i++) begin
            wreq2 = 1;
            waddr2 = (i < 4) ? 13'h300 + 13'(i) : 13'h304;
            wdata2 = (i < 4) ? 8'h10 + 8'(i) : 8'h99;
            tick();
            check("ovf_during_fill", 32'(ovf2), (i == 4) ? 32'd1 : 32'd0);
        end
        wreq2 = 0;
        repeat (4) tick();
        rreq2 = 0;
        repeat (6) tick();
        check("ovf_drain_busy", 32'(busy2), 32'd0);
        check("ovf_sticky", 32'(ovf2), 32'd1);
        refill(1, 13'h300, 32'h13121110);
        refill(1, 13'h304, 32'h00000000);
        check("ovf_still_set", 32'(ovf2), 32'd1);

        // Duplicate suppression: held identical write enqueues once.
        wreq = 1; waddr = 13'h010; wdata = 8'h77;
        tick();
        check("dup_busy_e1", 32'(busy), 32'd1);
        tick();
        check("dup_busy_e2", 32'(busy), 32'd0);
        tick();
        check("dup_busy_e3", 32'(busy), 32'd0);
        wreq = 0;
        tick();
        refill(0, 13'h010, 32'h00000077);

        // Abort: request dropped at T0+2, no pulse, back to IDLE.
        rreq = 1; raddr = 13'h000;
        tick();
        tick();
        rreq = 0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        repeat (6) tick();

        // Reset in the middle of RD_WAIT clears outputs at once.
        rreq = 1; raddr = 13'h000;
        tick();
        tick();
        #2 resetn = 1'b0;
        #1;
        check("midrst_rdata",  rdata,  32'd0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_ovf2",   32'(ovf2),   32'd0);
        rreq = 0;
        @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        refill(0, 13'h003, 32'hDDCCBBAA);

        repeat (5) tick();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
